vote_tally_session: RTL and testbench
=====================================

// Module: vote_tally_session
//
// PURPOSE
// Parametrised weighted voting tally with explicit voting sessions. Three voter classes
// (normal, VIP, VVIP) of configurable count and weight cast sticky votes (a vote cannot
// be withdrawn). The running weighted total is held in a register. A start/close FSM
// bounds each session and gives a final saturated result with a threshold-pass flag.
// Instantiated by the vote-display top level; succeeds the fixed 32/8/1 voter.
//
// PARAMETERS
// N_NP    32  number of normal voters
// N_VIP    8  number of VIP voters
// N_VVIP   1  number of VVIP voters
// W_NP     1  weight per normal vote
// W_VIP    4  weight per VIP vote
// W_VVIP  16  weight per VVIP vote
// RES_W    8  result width; total saturates at 2**RES_W-1
// THRESH  40  pass threshold; pass = (result >= THRESH)
//
// PORTS
// clk     in   1       rising-edge clock
// reset   in   1       asynchronous, active-high
// start   in   1       pulse: open a new session, clearing all latched votes
// close   in   1       pulse: end the session, freezing the result
// np      in   N_NP    normal vote bits, 1 = vote this cycle
// vip     in   N_VIP   VIP vote bits
// vvip    in   N_VVIP  VVIP vote bits
// result  out  RES_W   registered weighted total, saturated
// open    out  1       1 while state == OPEN
// done    out  1       1 while state == CLOSED (result final)
// pass    out  1       registered; valid only when done = 1, else 0
// sat     out  1       sticky: true weighted sum exceeded 2**RES_W-1 this session
//
// BEHAVIOUR
// - Reset (async): state = IDLE; vote latches, result, sat, pass, open, done all 0.
// - FSM states: IDLE(0), OPEN(1), CLOSED(2). Encoding is fixed at 2 bits.
//   IDLE:   start -> OPEN (latches cleared). A close in the same cycle is ignored.
//           close alone is ignored.
//   OPEN:   start -> stay OPEN, clear latches and result; that cycle's votes are dropped.
//           Otherwise, on each edge: latch |= inputs, and result/sat are recomputed
//           from the new latch value. close -> CLOSED; votes presented in the close
//           cycle are counted.
//   CLOSED: latches, result and sat are frozen. start -> OPEN with latches cleared.
//           close is ignored.
// - Votes are ignored in IDLE and CLOSED. A vote bit held high counts once.
// - Latency: a vote sampled at edge k is visible in result after edge k (one cycle).
// - Arithmetic: sum = W_NP*popcount(np_l) + W_VIP*popcount(vip_l) + W_VVIP*popcount(vvip_l).
//   The internal width must hold the maximum sum without overflow. result = min(sum, 2**RES_W-1).
//   sat = (sum > 2**RES_W-1), sticky until the next start or reset.
// - pass is registered on the close edge as (saturated result >= THRESH). It holds
//   through CLOSED and is cleared on start.
// - Reset mid-session: all state is lost immediately. No partial result is retained.
//
// STRUCTURE
// - Header vote_defs.vh: state localparams ST_IDLE/ST_OPEN/ST_CLOSED and the
//   default weights. Shared with the display top level.
// - Sub-module weighted_popcount #(N, W, OUT_W): purely combinational.
//   Computes W*popcount(vec). There is one instance per class. The top module adds
//   the three instance outputs, saturates the total, and holds the FSM and registers.
//
// TESTING
// 1 Defaults. reset, start, then np=32'h0000_000F for 1 cycle -> result=4 next cycle, open=1.
// 2 Sticky vote. The same np bit is held for 5 cycles, then vip=8'h01 -> result=1, then 5.
//   vvip=1 -> 21. Then close -> done=1, result=21, pass=0.
// 3 Saturation. All np, vip and vvip set in one cycle (sum 32+32+16=80 with RES_W=8 is
//   no saturation). Re-run with RES_W=6 -> result=63, sat=1, pass=1 after close.
// 4 Priority. In IDLE, start and close together -> OPEN. In OPEN with result=9, start
//   together with np=1 -> result=0 next cycle, and the vote is dropped.
// 5 Frozen. In CLOSED, toggle all vote inputs for 10 cycles -> result unchanged. Then
//   start -> result=0, pass=0, sat=0, open=1.
// 6 Async reset mid-OPEN (result=12). Assert reset between clock edges -> all outputs 0
//   immediately, state IDLE. Votes after release are ignored until start.

Source files
------------

// File: rtl/vote_tally_session_pkg.sv
// Shared definitions for the weighted session voter.
// Holds the FSM state constants, the default class sizes/weights, and a
// helper that sizes the internal sum so the largest possible total fits.
package vote_tally_session_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_OPEN   = 2'd1;
    localparam logic [1:0] ST_CLOSED = 2'd2;

    localparam int DEF_N_NP   = 32;
    localparam int DEF_N_VIP  = 8;
    localparam int DEF_N_VVIP = 1;
    localparam int DEF_W_NP   = 1;
    localparam int DEF_W_VIP  = 4;
    localparam int DEF_W_VVIP = 16;
    localparam int DEF_RES_W  = 8;
    localparam int DEF_THRESH = 40;

    // Bits needed to represent 0..max_sum without overflow.
    function automatic int sum_width(input int max_sum);
        return (max_sum < 1) ? 1 : $clog2(max_sum + 1);
    endfunction

endpackage

// File: rtl/vote_tally_session_if.sv
// Session/vote bus between the voting front end and the tally.
// master: drives start, close and the three vote vectors; observes the tally.
// slave : the tally; drives result, open, done, pass, sat.
interface vote_tally_session_if
    import vote_tally_session_pkg::*;
#(
    parameter int N_NP   = DEF_N_NP,
    parameter int N_VIP  = DEF_N_VIP,
    parameter int N_VVIP = DEF_N_VVIP,
    parameter int RES_W  = DEF_RES_W
);
    logic              start;
    logic              close;
    logic [N_NP-1:0]   np;
    logic [N_VIP-1:0]  vip;
    logic [N_VVIP-1:0] vvip;
    logic [RES_W-1:0]  result;
    logic              open;
    logic              done;
    logic              pass;
    logic              sat;

    modport master (
        output start, close, np, vip, vvip,
        input  result, open, done, pass, sat
    );

    modport slave (
        input  start, close, np, vip, vvip,
        output result, open, done, pass, sat
    );
endinterface

// File: rtl/vote_tally_session_weighted_popcount.sv
// weighted_popcount: purely combinational W * popcount(vec).
// Ports: vec (N bits in), wsum (OUT_W bits out). OUT_W must hold N*W.
module weighted_popcount #(
    parameter int N     = 8,
    parameter int W     = 1,
    parameter int OUT_W = 8
) (
    input  logic [N-1:0]     vec,
    output logic [OUT_W-1:0] wsum
);
    localparam int CNT_W = $clog2(N + 1);

    logic [CNT_W-1:0] cnt;

    always_comb begin
        cnt = '0;
        for (int i = 0; i < N; i++) begin
            cnt = cnt + CNT_W'(vec[i]);
        end
        wsum = OUT_W'(32'(cnt) * W);
    end
endmodule

// File: rtl/vote_tally_session.sv
// vote_tally_session: weighted voting tally bounded by start/close sessions.
// Ports: clk, reset (async, active-high), bus (slave modport: start, close,
// np/vip/vvip votes in; result, open, done, pass, sat out).
// Votes are sticky latches; result is the saturated weighted sum of the
// latches, updated one edge after the vote is sampled.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | no session; votes and close ignored, start opens one
// ST_OPEN   | collecting votes; start restarts, close finalises
// ST_CLOSED | result/sat/pass frozen; start opens a fresh session
module vote_tally_session
    import vote_tally_session_pkg::*;
#(
    parameter int N_NP   = DEF_N_NP,
    parameter int N_VIP  = DEF_N_VIP,
    parameter int N_VVIP = DEF_N_VVIP,
    parameter int W_NP   = DEF_W_NP,
    parameter int W_VIP  = DEF_W_VIP,
    parameter int W_VVIP = DEF_W_VVIP,
    parameter int RES_W  = DEF_RES_W,
    parameter int THRESH = DEF_THRESH
) (
    input logic                 clk,
    input logic                 reset,
    vote_tally_session_if.slave bus
);
    localparam int          SUM_MAX = N_NP * W_NP + N_VIP * W_VIP + N_VVIP * W_VVIP;
    localparam int          SUM_W   = sum_width(SUM_MAX);
    localparam logic [31:0] RES_MAX = 32'((64'd1 << RES_W) - 64'd1);

    logic [1:0]        state;
    logic [N_NP-1:0]   np_l;
    logic [N_VIP-1:0]  vip_l;
    logic [N_VVIP-1:0] vvip_l;
    logic [RES_W-1:0]  result_q;
    logic              sat_q;
    logic              pass_q;

    logic [N_NP-1:0]   np_next;
    logic [N_VIP-1:0]  vip_next;
    logic [N_VVIP-1:0] vvip_next;
    logic [SUM_W-1:0]  wsum_np;
    logic [SUM_W-1:0]  wsum_vip;
    logic [SUM_W-1:0]  wsum_vvip;
    logic [31:0]       sum_ext;
    logic              over;
    logic [RES_W-1:0]  result_next;

    // The tally is computed from the latch value that will exist after this
    // edge, so a vote shows up in result one cycle after it is sampled.
    assign np_next   = np_l | bus.np;
    assign vip_next  = vip_l | bus.vip;
    assign vvip_next = vvip_l | bus.vvip;

    weighted_popcount #(.N(N_NP),   .W(W_NP),   .OUT_W(SUM_W)) u_pc_np   (.vec(np_next),   .wsum(wsum_np));
    weighted_popcount #(.N(N_VIP),  .W(W_VIP),  .OUT_W(SUM_W)) u_pc_vip  (.vec(vip_next),  .wsum(wsum_vip));
    weighted_popcount #(.N(N_VVIP), .W(W_VVIP), .OUT_W(SUM_W)) u_pc_vvip (.vec(vvip_next), .wsum(wsum_vvip));

    assign sum_ext     = 32'(wsum_np) + 32'(wsum_vip) + 32'(wsum_vvip);
    assign over        = sum_ext > RES_MAX;
    assign result_next = over ? RES_MAX[RES_W-1:0] : sum_ext[RES_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            np_l     <= '0;
            vip_l    <= '0;
            vvip_l   <= '0;
            result_q <= '0;
            sat_q    <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_CLOSED: begin
                    if (bus.start) begin
                        state    <= ST_OPEN;
                        np_l     <= '0;
                        vip_l    <= '0;
                        vvip_l   <= '0;
                        result_q <= '0;
                        sat_q    <= 1'b0;
                        pass_q   <= 1'b0;
                    end
                end
                ST_OPEN: begin
                    // A restart wins over close and drops that cycle's votes.
                    if (bus.start) begin
                        np_l     <= '0;
                        vip_l    <= '0;
                        vvip_l   <= '0;
                        result_q <= '0;
                        sat_q    <= 1'b0;
                        pass_q   <= 1'b0;
                    end else begin
                        np_l     <= np_next;
                        vip_l    <= vip_next;
                        vvip_l   <= vvip_next;
                        result_q <= result_next;
                        sat_q    <= sat_q | over;
                        if (bus.close) begin
                            state  <= ST_CLOSED;
                            pass_q <= 32'(result_next) >= 32'(THRESH);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.result = result_q;
    assign bus.sat    = sat_q;
    assign bus.pass   = pass_q;
    assign bus.open   = (state == ST_OPEN);
    assign bus.done   = (state == ST_CLOSED);
endmodule

// File: tb/tb_vote_tally_session.sv
module tb_vote_tally_session;

    localparam int WNP = 1, WVIP = 4, WVVIP = 16, THR = 40;

    logic clk;
    logic reset;

    vote_tally_session_if #(.RES_W(8)) bus8 ();
    vote_tally_session_if #(.RES_W(6)) bus6 ();

    vote_tally_session #(.RES_W(8)) u_dut8 (.clk(clk), .reset(reset), .bus(bus8));
    vote_tally_session #(.RES_W(6)) u_dut6 (.clk(clk), .reset(reset), .bus(bus6));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int tag;
        int r8, s8, p8;
        int r6, s6, p6;
        int op, dn;
    } exp_t;

    exp_t q[$];
    event chk_now;
    int checks = 0;
    int failures = 0;
    int tag_no = 0;

    // Reference model: session phase plus the set of voters who have voted.
    typedef enum {PH_IDLE, PH_OPEN, PH_DONE} phase_t;
    phase_t ph;
    bit [31:0] m_np;
    bit [7:0]  m_vip;
    bit        m_vvip;
    int m_r8, m_s8, m_p8, m_r6, m_s6, m_p6;

    task automatic model_clear();
        m_np = '0; m_vip = '0; m_vvip = 1'b0;
        m_r8 = 0; m_s8 = 0; m_p8 = 0; m_r6 = 0; m_s6 = 0; m_p6 = 0;
    endtask

    task automatic model_reset();
        ph = PH_IDLE;
        model_clear();
    endtask

    task automatic model_edge(bit st, bit cl, bit [31:0] n, bit [7:0] v, bit vv);
        int total;
        if (ph == PH_OPEN) begin
            if (st) model_clear();
            else begin
                m_np |= n; m_vip |= v; m_vvip |= vv;
                total = WNP * $countones(m_np) + WVIP * $countones(m_vip) + WVVIP * int'(m_vvip);
                m_r8 = (total > 255) ? 255 : total;
                m_r6 = (total > 63) ? 63 : total;
                if (total > 255) m_s8 = 1;
                if (total > 63) m_s6 = 1;
                if (cl) begin
                    ph = PH_DONE;
                    m_p8 = (m_r8 >= THR) ? 1 : 0;
                    m_p6 = (m_r6 >= THR) ? 1 : 0;
                end
            end
        end else if (st) begin
            ph = PH_OPEN;
            model_clear();
        end
    endtask

    task automatic push_expected();
        exp_t e;
        tag_no++;
        e.tag = tag_no;
        e.r8 = m_r8; e.s8 = m_s8; e.p8 = m_p8;
        e.r6 = m_r6; e.s6 = m_s6; e.p6 = m_p6;
        e.op = (ph == PH_OPEN) ? 1 : 0;
        e.dn = (ph == PH_DONE) ? 1 : 0;
        q.push_back(e);
    endtask

    task automatic chk(string nm, int tag, int act, int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s tag=%0d got=%0d expected=%0d", nm, tag, act, req);
        end
    endtask

    // Monitor: pops one expectation per presented output sample.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or chk_now);
            #1;
            while (q.size() > 0) begin
                e = q.pop_front();
                chk("result8", e.tag, int'(bus8.result), e.r8);
                chk("sat8",    e.tag, int'(bus8.sat),    e.s8);
                chk("pass8",   e.tag, int'(bus8.pass),   e.p8);
                chk("open8",   e.tag, int'(bus8.open),   e.op);
                chk("done8",   e.tag, int'(bus8.done),   e.dn);
                chk("result6", e.tag, int'(bus6.result), e.r6);
                chk("sat6",    e.tag, int'(bus6.sat),    e.s6);
                chk("pass6",   e.tag, int'(bus6.pass),   e.p6);
                chk("open6",   e.tag, int'(bus6.open),   e.op);
                chk("done6",   e.tag, int'(bus6.done),   e.dn);
            end
        end
    end

    task automatic drive(bit st, bit cl, bit [31:0] n, bit [7:0] v, bit vv);
        bus8.start = st; bus8.close = cl; bus8.np = n; bus8.vip = v; bus8.vvip = vv;
        bus6.start = st; bus6.close = cl; bus6.np = n; bus6.vip = v; bus6.vvip = vv;
    endtask

    // One clock: drive at the falling edge, predict, let the rising edge happen.
    task automatic step(bit st, bit cl, bit [31:0] n, bit [7:0] v, bit vv);
        drive(st, cl, n, v, vv);
        model_edge(st, cl, n, v, vv);
        push_expected();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reset asserted between edges; outputs must clear without a clock.
    task automatic async_reset();
        #2 reset = 1'b1;
        model_reset();
        push_expected();
        -> chk_now;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog tag=%0d got=timeout expected=finish", tag_no);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        drive(0, 0, '0, '0, 1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        push_expected();
        -> chk_now;
        @(negedge clk);
        reset = 1'b0;

        // Defaults: four normal votes
        step(1, 0, '0, '0, 0);
        step(0, 0, 32'h0000_000F, '0, 0);
        step(0, 0, '0, '0, 0);

        // Sticky: same bit held, then VIP, then VVIP, then close
        step(1, 0, '0, '0, 0);
        repeat (5) step(0, 0, 32'h1, '0, 0);
        step(0, 0, 32'h1, 8'h01, 0);
        step(0, 0, '0, '0, 1);
        step(0, 1, '0, '0, 0);
        step(0, 0, '0, '0, 0);

        // Saturation: everything at once (80, saturates only at 6 bits)
        step(1, 0, '0, '0, 0);
        step(0, 0, 32'hFFFF_FFFF, 8'hFF, 1);
        step(0, 1, '0, '0, 0);
        step(0, 0, '0, '0, 0);

        // Priority: start+close in IDLE, restart with a vote in OPEN
        async_reset();
        step(0, 1, 32'hFF, '0, 0);
        step(1, 1, '0, '0, 0);
        step(0, 0, 32'h1FF, '0, 0);
        step(1, 0, 32'h1, '0, 0);
        step(0, 0, '0, '0, 0);

        // Frozen: close counts its votes, then toggling has no effect
        step(0, 0, 32'h3, '0, 0);
        step(0, 1, '0, 8'h01, 0);
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) step(0, 1, 32'hFFFF_FFFF, 8'hFF, 1);
            else            step(0, 0, '0, '0, 0);
        end
        step(1, 0, '0, '0, 0);

        // Async reset mid-OPEN at result 12, then votes ignored until start
        step(0, 0, 32'h0000_0FFF, '0, 0);
        async_reset();
        step(0, 0, 32'hFFFF_FFFF, 8'hFF, 1);
        step(0, 1, 32'h5, '0, 0);
        step(1, 0, '0, '0, 0);
        step(0, 0, 32'h2, '0, 0);

        // Randomised sessions with sparse votes
        for (int i = 0; i < 400; i++) begin
            bit st, cl;
            bit [31:0] n;
            bit [7:0] v;
            st = ($urandom_range(0, 19) == 0);
            cl = ($urandom_range(0, 14) == 0);
            n  = $urandom & $urandom & $urandom & $urandom;
            v  = 8'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 149) == 0) async_reset();
            else step(st, cl, n, v, ($urandom_range(0, 29) == 0));
        end

        drive(0, 0, '0, '0, 0);
        repeat (3) @(negedge clk);
        chk("queue_drained", tag_no, q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
